// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared unit IDs, station tags and width defaults for the CDB arbiter
package cdb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int TAG_W_DEF  = 3;

    localparam logic [1:0] UNIT_NONE = 2'b00;
    localparam logic [1:0] UNIT_MULT = 2'b01;
    localparam logic [1:0] UNIT_ADD  = 2'b10;
    localparam logic [1:0] UNIT_LDST = 2'b11;

    localparam logic [2:0] RS_NONE = 3'b000;
    localparam logic [2:0] RS_MULT = 3'b001;
    localparam logic [2:0] RS_ADD  = 3'b010;
    localparam logic [2:0] RS_ST   = 3'b011;
    localparam logic [2:0] RS_LD   = 3'b100;

endpackage

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - one-hot grant for three requesters; round-robin when CDB_RR_EN is defined, else fixed priority
module rr_pick3
    import cdb_pkg::*;
(
    input  logic [2:0] req,
`ifdef CDB_RR_EN
    input  logic [1:0] last_grant,
`endif
    output logic [2:0] gnt
);

    // Grant the first requester found in the order a, b, c (bit indices).
    function automatic logic [2:0] pick(input logic [2:0] r, input int a, input int b, input int c);
        logic [2:0] g;
        g = 3'b000;
        if (r[a])      g[a] = 1'b1;
        else if (r[b]) g[b] = 1'b1;
        else if (r[c]) g[c] = 1'b1;
        return g;
    endfunction

`ifdef CDB_RR_EN
    always_comb begin
        gnt = 3'b000;
        case (last_grant)
            UNIT_MULT: gnt = pick(req, 1, 2, 0);
            UNIT_ADD:  gnt = pick(req, 2, 0, 1);
            default:   gnt = pick(req, 0, 1, 2);
        endcase
    end
`else
    always_comb begin
        gnt = 3'b000;
        gnt = pick(req, 0, 1, 2);
    end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common data bus arbiter for MULT/ADD/LD-ST results; CDB_RR_EN selects round-robin
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          req_valid,
    output logic [2:0]          req_ready,
    input  logic [3*TAG_W-1:0]  req_tag,
    input  logic [3*DATA_W-1:0] req_data,
    input  logic                flush,
    output logic                cdb_valid,
    output logic [TAG_W-1:0]    cdb_tag,
    output logic [DATA_W-1:0]   cdb_data,
    output logic [1:0]          cdb_src,
    output logic                tag_err
);

    logic [2:0]        pick_gnt;
    logic [2:0]        grant;
    logic              xfer;
    logic              bad_tag;
    logic [TAG_W-1:0]  sel_tag;
    logic [DATA_W-1:0] sel_data;
    logic [1:0]        sel_src;

    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q,  cdb_data_d;
    logic [1:0]        cdb_src_q,   cdb_src_d;
    logic              tag_err_q,   tag_err_d;

`ifdef CDB_RR_EN
    logic [1:0]        last_grant_q, last_grant_d;

    rr_pick3 u_pick (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .gnt        (pick_gnt)
    );
`else
    rr_pick3 u_pick (
        .req (req_valid),
        .gnt (pick_gnt)
    );
`endif

    always_comb begin
        grant    = (reset || flush) ? 3'b000 : pick_gnt;
        xfer     = |grant;
        sel_tag  = '0;
        sel_data = '0;
        sel_src  = UNIT_NONE;
        for (int i = 0; i < 3; i++) begin
            if (grant[i]) begin
                sel_tag  = req_tag[i*TAG_W +: TAG_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
                sel_src  = 2'(i + 1);
            end
        end
        // A tagless result is consumed but never broadcast.
        bad_tag     = xfer && (sel_tag == '0);
        cdb_valid_d = xfer && !bad_tag;
        cdb_tag_d   = cdb_valid_d ? sel_tag  : '0;
        cdb_data_d  = cdb_valid_d ? sel_data : '0;
        cdb_src_d   = cdb_valid_d ? sel_src  : UNIT_NONE;
        tag_err_d   = tag_err_q | bad_tag;
`ifdef CDB_RR_EN
        last_grant_d = xfer ? sel_src : last_grant_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= UNIT_NONE;
            tag_err_q   <= 1'b0;
`ifdef CDB_RR_EN
            last_grant_q <= UNIT_LDST;
`endif
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
            tag_err_q   <= tag_err_d;
`ifdef CDB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Reset arriving while a broadcast is on the bus squashes it in that same cycle.
    assign req_ready = grant;
    assign cdb_valid = cdb_valid_q & ~reset;
    assign cdb_tag   = reset ? '0 : cdb_tag_q;
    assign cdb_data  = reset ? '0 : cdb_data_q;
    assign cdb_src   = reset ? UNIT_NONE : cdb_src_q;
    assign tag_err   = tag_err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter (directed vectors, both arbitration modes)
module tb_cdb_arbiter;

`ifdef CDB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [8:0]  req_tag;
    logic [95:0] req_data;
    logic        flush;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [1:0]  cdb_src;
    logic        tag_err;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    logic [36:0] sb[$];

    always #5 clk = ~clk;

    cdb_arbiter #(.DATA_W(32), .TAG_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .flush     (flush),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src),
        .tag_err   (tag_err)
    );

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (cdb_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bcast got tag=%0h data=%0h src=%0h, none expected", cdb_tag, cdb_data, cdb_src);
                end else begin
                    logic [36:0] e;
                    e = sb.pop_front();
                    if ({cdb_tag, cdb_data, cdb_src} !== e) begin
                        errors++;
                        $display("FAIL bcast got tag=%0h data=%0h src=%0h, want tag=%0h data=%0h src=%0h",
                                 cdb_tag, cdb_data, cdb_src, e[36:34], e[33:2], e[1:0]);
                    end
                end
            end else if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== 38'd0) begin
                errors++;
                $display("FAIL idle_bus got valid=%b tag=%0h data=%0h src=%0h, want all zero", cdb_valid, cdb_tag, cdb_data, cdb_src);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; exp is the hand-computed req_ready for this cycle.
    task automatic step(input string name, input logic [2:0] v,
                        input logic [2:0] t0, input logic [2:0] t1, input logic [2:0] t2,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                        input logic fl, input logic rs, input logic [2:0] exp);
        logic [2:0]  tg[3];
        logic [31:0] dt[3];
        @(posedge clk);
        #1;
        reset     = rs;
        flush     = fl;
        req_valid = v;
        req_tag   = {t2, t1, t0};
        req_data  = {d2, d1, d0};
        tg = '{t0, t1, t2};
        dt = '{d0, d1, d2};
        @(negedge clk);
        chk({name, "_ready"}, {29'd0, req_ready}, {29'd0, exp});
        for (int k = 0; k < 3; k++)
            if (exp[k] && tg[k] != 3'd0)
                sb.push_back({tg[k], dt[k], 2'(k + 1)});
    endtask

    task automatic idle(input string name);
        step(name, 3'b000, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1'b0, 1'b0, 3'b000);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; req_valid = '0; req_tag = '0; req_data = '0;
        step("rst0", 3'b111, 3'd1, 3'd2, 3'd4, 1, 2, 3, 1'b0, 1'b1, 3'b000);
        mon_en = 1'b1;
        step("rst1", 3'b000, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1'b0, 1'b1, 3'b000);
        idle("post_rst");
        chk("tag_err_reset", {31'd0, tag_err}, 32'd0);

        // MULT alone
        step("mult_only", 3'b001, 3'd1, 3'd0, 3'd0, 32'h5, 0, 0, 1'b0, 1'b0, 3'b001);
        idle("mult_bcast");

        // All three held for three cycles, from a fresh pointer
        step("rst_a", 3'b000, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1'b0, 1'b1, 3'b000);
        step("all_1", 3'b111, 3'd1, 3'd2, 3'd4, 32'ha, 32'hb, 32'hc, 1'b0, 1'b0, 3'b001);
        step("all_2", 3'b111, 3'd1, 3'd2, 3'd4, 32'ha, 32'hb, 32'hc, 1'b0, 1'b0, RR ? 3'b010 : 3'b001);
        step("all_3", 3'b111, 3'd1, 3'd2, 3'd4, 32'ha, 32'hb, 32'hc, 1'b0, 1'b0, RR ? 3'b100 : 3'b001);

        // Flush blocks grants; pointer unchanged afterwards
        step("flush", 3'b110, 3'd0, 3'd2, 3'd3, 0, 32'h20, 32'h30, 1'b1, 1'b0, 3'b000);
        step("flush_bus", 3'b110, 3'd0, 3'd2, 3'd3, 0, 32'h20, 32'h30, 1'b0, 1'b0, 3'b010);
        idle("add_bcast");

        // Idle gap, then MULT+ADD
        for (int i = 0; i < 5; i++) idle("gap");
        step("ma_1", 3'b011, 3'd1, 3'd2, 3'd0, 32'h11, 32'h22, 0, 1'b0, 1'b0, 3'b001);
        step("ma_2", 3'b011, 3'd1, 3'd2, 3'd0, 32'h11, 32'h22, 0, 1'b0, 1'b0, RR ? 3'b010 : 3'b001);
        step("ldst_only", 3'b100, 3'd0, 3'd0, 3'd3, 0, 0, 32'hdead, 1'b0, 1'b0, 3'b100);
        idle("ldst_bcast");

        // Tagless ADD result: consumed, not broadcast, sticky error
        step("bad_tag", 3'b010, 3'd0, 3'd0, 3'd0, 0, 32'h99, 0, 1'b0, 1'b0, 3'b010);
        idle("bad_tag_bus");
        chk("tag_err_set", {31'd0, tag_err}, 32'd1);
        step("flush2", 3'b000, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1'b1, 1'b0, 3'b000);
        idle("after_flush2");
        chk("tag_err_flush", {31'd0, tag_err}, 32'd1);

        // Reset right after a MULT transfer squashes its broadcast
        step("pre_rst", 3'b001, 3'd1, 3'd0, 3'd0, 32'h77, 0, 0, 1'b0, 1'b0, 3'b001);
        void'(sb.pop_back());
        step("mid_rst", 3'b001, 3'd1, 3'd0, 3'd0, 32'h77, 0, 0, 1'b0, 1'b1, 3'b000);
        step("restart", 3'b011, 3'd1, 3'd2, 3'd0, 32'h44, 32'h55, 0, 1'b0, 1'b0, 3'b001);
        chk("tag_err_cleared", {31'd0, tag_err}, 32'd0);
        idle("restart_bcast");
        idle("tail");

        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
